// File: rtl/hls_ctrl_pkg.sv
// hls_ctrl_pkg: state type and debug codes shared by all HLS kernel controllers.
package hls_ctrl_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

    localparam logic [31:0] DBG_IDLE = 32'd0;
    localparam logic [31:0] DBG_BUSY = 32'd200000;
    localparam logic [31:0] DBG_DONE = 32'd200001;

    function automatic logic [31:0] state_code(state_e s);
        return s == ST_IDLE ? DBG_IDLE : s == ST_DONE ? DBG_DONE : DBG_BUSY;
    endfunction

endpackage

// File: rtl/loop_pipeline_ctrl_if.sv
// loop_pipeline_ctrl_if: kernel-FSM / datapath-facing bundle of the loop sequencer.
interface loop_pipeline_ctrl_if #(
    parameter int DEPTH = 5,
    parameter int IDX_W = 32
);
    logic                   start;
    logic                   stall;
    logic                   issue;
    logic [IDX_W-1:0]       issue_idx;
    logic [DEPTH-1:0]       stage_valid;
    logic [DEPTH*IDX_W-1:0] stage_idx;
    logic                   busy;
    logic                   valid;
    logic [31:0]            global_state_dbg;

    modport master (
        output start, stall,
        input  issue, issue_idx, stage_valid, stage_idx, busy, valid, global_state_dbg
    );

    modport slave (
        input  start, stall,
        output issue, issue_idx, stage_valid, stage_idx, busy, valid, global_state_dbg
    );
endinterface

// File: rtl/ii_timer.sv
// ii_timer: loadable down-counter that stops at zero; holds while stalled.
module ii_timer #(
    parameter int W      = 1,
    parameter int RELOAD = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    input  logic clr,
    input  logic load,
    output logic zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else if (!stall)
            cnt <= clr ? '0 : load ? W'(RELOAD) : cnt != '0 ? cnt - W'(1) : cnt;

    assign zero = cnt == '0;
endmodule

// File: rtl/loop_pipeline_ctrl.sv
// loop_pipeline_ctrl: issues NUM_ITERS iterations every II cycles into a DEPTH-stage
// pipeline, tracks stage occupancy/index and flags completion when the last one drains.
module loop_pipeline_ctrl
    import hls_ctrl_pkg::*;
#(
    parameter int NUM_ITERS = 6,
    parameter int DEPTH     = 5,
    parameter int II        = 1,
    parameter int IDX_W     = 32
) (
    input logic clk,
    input logic rst,
    loop_pipeline_ctrl_if.slave bus
);
    localparam int CW = $clog2(NUM_ITERS + 1);
    localparam int TW = II > 1 ? $clog2(II) : 1;
    localparam int SW = DEPTH * IDX_W;

    state_e          state, state_nx;
    logic [CW-1:0]   issued;
    logic [DEPTH-1:0] sv;
    logic [SW-1:0]   si;
    logic            vld;
    logic            timer_zero;
    logic            launch;
    logic            last_out;

    assign launch    = !bus.stall && bus.start && (state == ST_IDLE || state == ST_DONE);
    assign bus.issue = state == ST_RUN && timer_zero && issued < CW'(NUM_ITERS) && !bus.stall;
    assign last_out  = sv[DEPTH-1] && si[(DEPTH-1)*IDX_W +: IDX_W] == IDX_W'(NUM_ITERS - 1);

    ii_timer #(.W(TW), .RELOAD(II - 1)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .stall (bus.stall),
        .clr   (launch),
        .load  (bus.issue),
        .zero  (timer_zero)
    );

    always_comb begin
        state_nx = state;
        if (launch)
            state_nx = ST_RUN;
        else if (state == ST_RUN && bus.issue && issued == CW'(NUM_ITERS - 1))
            state_nx = ST_DRAIN;
        else if (state == ST_DRAIN && !bus.stall && last_out)
            state_nx = ST_DONE;
    end

    // Stage 0 loads a zero index on bubbles so idle stages always read back as zero.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state  <= ST_IDLE;
            issued <= '0;
            sv     <= '0;
            si     <= '0;
            vld    <= 1'b0;
        end else if (!bus.stall) begin
            state <= state_nx;
            if (launch) begin
                issued <= '0;
                sv     <= '0;
                si     <= '0;
                vld    <= 1'b0;
            end else begin
                if (bus.issue)
                    issued <= issued + CW'(1);
                sv <= DEPTH'({sv, bus.issue});
                si <= SW'({si, bus.issue ? bus.issue_idx : IDX_W'(0)});
                if (state == ST_DRAIN && last_out)
                    vld <= 1'b1;
            end
        end

    assign bus.issue_idx        = IDX_W'(issued);
    assign bus.stage_valid      = sv;
    assign bus.stage_idx        = si;
    assign bus.busy             = state == ST_RUN || state == ST_DRAIN;
    assign bus.valid            = vld;
    assign bus.global_state_dbg = state_code(state);
endmodule

// File: tb/tb_loop_pipeline_ctrl.sv
// tb_loop_pipeline_ctrl: three configurations checked each cycle against a schedule
// model derived from the issue/occupancy timing rules.
module tb_loop_pipeline_ctrl;
    logic clk, rst, start, stall;
    int   sel;
    int   t;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   nn[3]  = '{6, 3, 1};
    int   dd[3]  = '{5, 2, 1};
    int   iii[3] = '{1, 2, 1};

    loop_pipeline_ctrl_if #(.DEPTH(5), .IDX_W(32)) ia ();
    loop_pipeline_ctrl_if #(.DEPTH(2), .IDX_W(32)) ib ();
    loop_pipeline_ctrl_if #(.DEPTH(1), .IDX_W(32)) ic ();

    assign ia.start = start && sel == 0;
    assign ia.stall = stall && sel == 0;
    assign ib.start = start && sel == 1;
    assign ib.stall = stall && sel == 1;
    assign ic.start = start && sel == 2;
    assign ic.stall = stall && sel == 2;

    loop_pipeline_ctrl #(.NUM_ITERS(6), .DEPTH(5), .II(1), .IDX_W(32)) u_a (.clk(clk), .rst(rst), .bus(ia));
    loop_pipeline_ctrl #(.NUM_ITERS(3), .DEPTH(2), .II(2), .IDX_W(32)) u_b (.clk(clk), .rst(rst), .bus(ib));
    loop_pipeline_ctrl #(.NUM_ITERS(1), .DEPTH(1), .II(1), .IDX_W(32)) u_c (.clk(clk), .rst(rst), .bus(ic));

    logic         o_issue, o_busy, o_valid;
    logic [31:0]  o_idx, o_dbg;
    logic [7:0]   o_sv;
    logic [159:0] o_si;

    always_comb begin
        o_issue = sel == 0 ? ia.issue : sel == 1 ? ib.issue : ic.issue;
        o_busy  = sel == 0 ? ia.busy : sel == 1 ? ib.busy : ic.busy;
        o_valid = sel == 0 ? ia.valid : sel == 1 ? ib.valid : ic.valid;
        o_idx   = sel == 0 ? ia.issue_idx : sel == 1 ? ib.issue_idx : ic.issue_idx;
        o_dbg   = sel == 0 ? ia.global_state_dbg : sel == 1 ? ib.global_state_dbg : ic.global_state_dbg;
        o_sv    = sel == 0 ? 8'(ia.stage_valid) : sel == 1 ? 8'(ib.stage_valid) : 8'(ic.stage_valid);
        o_si    = sel == 0 ? 160'(ia.stage_idx) : sel == 1 ? 160'(ib.stage_idx) : 160'(ic.stage_idx);
    end

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic int fin_at();
        return (nn[sel] - 1) * iii[sel] + dd[sel] + 1;
    endfunction

    task automatic chk(input string tag, input string what, input logic [159:0] obs, input logic [159:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s/%s observed=%0h expected=%0h", tag, what, obs, exp);
        end
    endtask

    // t counts unstalled edges since the launching edge; -1 means idle since reset.
    task automatic check(input string tag, input bit stl);
        logic         e_issue, e_busy, e_valid;
        logic [31:0]  e_idx, e_dbg;
        logic [7:0]   e_sv;
        logic [159:0] e_si;
        e_issue = 0; e_busy = 0; e_valid = 0; e_idx = 0; e_dbg = 0; e_sv = 0; e_si = 0;
        if (t >= 0) begin
            for (int j = 0; j < nn[sel]; j++) begin
                if (j * iii[sel] == t && !stl) e_issue = 1;
                if (j * iii[sel] < t) e_idx++;
                for (int s = 0; s < dd[sel]; s++)
                    if (j * iii[sel] + 1 + s == t) begin
                        e_sv[s] = 1;
                        e_si[s*32 +: 32] = 32'(j);
                    end
            end
            e_valid = t >= fin_at();
            e_busy  = !e_valid;
            e_dbg   = e_valid ? 32'd200001 : 32'd200000;
        end
        chk(tag, "issue", 160'(o_issue), 160'(e_issue));
        chk(tag, "issue_idx", 160'(o_idx), 160'(e_idx));
        chk(tag, "stage_valid", 160'(o_sv), 160'(e_sv));
        chk(tag, "stage_idx", o_si, e_si);
        chk(tag, "busy", 160'(o_busy), 160'(e_busy));
        chk(tag, "valid", 160'(o_valid), 160'(e_valid));
        chk(tag, "dbg", 160'(o_dbg), 160'(e_dbg));
    endtask

    task automatic step(input bit st, input bit stl, input string tag);
        start = st;
        stall = stl;
        @(negedge clk);
        check(tag, stl);
        @(posedge clk);
        if (!stl) begin
            if (st && (t < 0 || t >= fin_at())) t = 0;
            else if (t >= 0) t++;
        end
        #1;
    endtask

    task automatic do_reset();
        start = 0;
        stall = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        t = -1;
    endtask

    task automatic run(input int cycles, input string tag);
        step(1, 0, tag);
        repeat (cycles) step(0, 0, tag);
    endtask

    task automatic rand_run(input int cycles, input string tag);
        repeat (cycles) step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, tag);
    endtask

    initial begin
        sel = 0;
        t = -1;
        do_reset();
        step(0, 0, "reset");
        run(16, "basic");
        run(13, "restart_done");
        step(1, 0, "start_in_run");
        step(0, 0, "start_in_run");
        step(0, 0, "start_in_run");
        step(1, 0, "start_in_run");
        repeat (10) step(0, 0, "start_in_run");
        run(6, "stall_drain");
        repeat (3) step(0, 1, "stall_drain");
        repeat (8) step(0, 0, "stall_drain");
        run(4, "mid_reset");
        #2 rst = 1;
        t = -1;
        #1 check("async_reset", 0);
        #1 rst = 0;
        @(posedge clk);
        #1;
        run(13, "after_reset");
        rand_run(150, "rand_a");
        sel = 1;
        do_reset();
        step(0, 0, "ii2_reset");
        run(10, "ii2");
        rand_run(120, "rand_b");
        sel = 2;
        do_reset();
        run(5, "single");
        rand_run(60, "rand_c");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
